sargantana_icache_ctrl: RTL and testbench

- Lookup/miss sequencer for the instruction cache.
- Accepts fetch requests and drives the synchronous tag/data array reads.
- Asserts the compare enable consumed by the tag checker, then decides hit or miss from the checker's per-way hit vector.
- On a miss: issues a line fill, selects a victim way, writes the line, and replays the lookup. Owns the per-set valid bits and flush.

---
 rtl/sargantana_icache_pkg.sv | 16 +
 rtl/sargantana_icache_victim_sel.sv | 23 ++
 rtl/sargantana_icache_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_sargantana_icache_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sargantana_icache_pkg.sv
// Shared types and constants for the instruction-cache lookup/miss sequencer.
// Optional perf counters in the top are enabled by defining ICACHE_PERF_CNT_EN.
package sargantana_icache_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    COMPARE   = 3'd1,
    MISS_REQ  = 3'd2,
    MISS_WAIT = 3'd3,
    REPLAY    = 3'd4,
    FLUSH     = 3'd5
  } ictrl_state_t;

  localparam int ICTRL_PERF_CNT_W = 32;

endpackage

// File: rtl/sargantana_icache_victim_sel.sv
// Picks the way to refill: lowest-index invalid way, else the round-robin way.
module sargantana_icache_victim_sel #(
  parameter int N_WAY = 4,
  parameter int PTR_W = $clog2(N_WAY)
) (
  input  logic [N_WAY-1:0] valid_bits,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [N_WAY-1:0] victim
);

  // Scanning downwards lets the lowest invalid way overwrite any earlier pick.
  always_comb begin
    victim = '0;
    victim[rr_ptr] = 1'b1;
    for (int i = N_WAY - 1; i >= 0; i--) begin
      if (!valid_bits[i]) begin
        victim    = '0;
        victim[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sargantana_icache_ctrl.sv
// Instruction-cache lookup/miss sequencer: array reads, hit/miss decision, line fill, replay, flush.
// Define ICACHE_PERF_CNT_EN to add saturating hit/miss counters.
module sargantana_icache_ctrl
  import sargantana_icache_pkg::*;
#(
  parameter int ICACHE_N_WAY     = 4,
  parameter int ICACHE_IDX_WIDTH = 6
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  logic [ICACHE_IDX_WIDTH-1:0] req_idx_i,
  input  logic                        tag_valid_i,
  input  logic                        kill_i,
  input  logic                        flush_i,
  input  logic [ICACHE_N_WAY-1:0]     cline_hit_i,
  output logic                        rd_en_o,
  output logic [ICACHE_IDX_WIDTH-1:0] rd_idx_o,
  output logic                        cmp_enable_q_o,
  output logic [ICACHE_N_WAY-1:0]     way_valid_bits_o,
  output logic                        resp_valid_o,
  output logic                        ifill_req_valid_o,
  input  logic                        ifill_req_ready_i,
  input  logic                        ifill_resp_valid_i,
  output logic [ICACHE_N_WAY-1:0]     wr_en_o,
  output logic [ICACHE_IDX_WIDTH-1:0] wr_idx_o
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [ICTRL_PERF_CNT_W-1:0] hit_cnt_o,
  output logic [ICTRL_PERF_CNT_W-1:0] miss_cnt_o
`endif
);

  localparam int PTR_W  = $clog2(ICACHE_N_WAY);
  localparam int N_SETS = 1 << ICACHE_IDX_WIDTH;

  ictrl_state_t                state_q, state_d;
  logic [ICACHE_IDX_WIDTH-1:0] idx_q, idx_d;
  logic [ICACHE_N_WAY-1:0]     valid_q [N_SETS];
  logic [PTR_W-1:0]            rr_q;
  logic                        kill_pend_q, kill_pend_d;
  logic                        flush_pend_q, flush_pend_d;
  logic [ICACHE_N_WAY-1:0]     set_valid;
  logic [ICACHE_N_WAY-1:0]     victim;
  logic                        fill_we;

  assign set_valid = valid_q[idx_q];

  sargantana_icache_victim_sel #(
    .N_WAY (ICACHE_N_WAY),
    .PTR_W (PTR_W)
  ) u_victim_sel (
    .valid_bits (set_valid),
    .rr_ptr     (rr_q),
    .victim     (victim)
  );

  // Outputs are held at zero while reset is asserted, whatever state is still registered.
  always_comb begin
    state_d           = state_q;
    idx_d             = idx_q;
    kill_pend_d       = kill_pend_q;
    flush_pend_d      = flush_pend_q;
    fill_we           = 1'b0;
    req_ready_o       = 1'b0;
    rd_en_o           = 1'b0;
    rd_idx_o          = '0;
    cmp_enable_q_o    = 1'b0;
    way_valid_bits_o  = '0;
    resp_valid_o      = 1'b0;
    ifill_req_valid_o = 1'b0;
    wr_en_o           = '0;
    wr_idx_o          = '0;
    if (!rst_i) begin
      wr_idx_o = idx_q;
      case (state_q)
        IDLE: begin
          req_ready_o = !(flush_i || flush_pend_q);
          if (flush_i || flush_pend_q) begin
            state_d = FLUSH;
          end else if (req_valid_i) begin
            rd_en_o  = 1'b1;
            rd_idx_o = req_idx_i;
            idx_d    = req_idx_i;
            state_d  = COMPARE;
          end
        end
        COMPARE: begin
          cmp_enable_q_o   = 1'b1;
          way_valid_bits_o = set_valid;
          if (kill_i) begin
            state_d = IDLE;
          end else if (flush_i) begin
            state_d = FLUSH;
          end else if (!tag_valid_i) begin
            rd_en_o  = 1'b1;
            rd_idx_o = idx_q;
          end else if (|cline_hit_i) begin
            resp_valid_o = 1'b1;
            state_d      = IDLE;
          end else begin
            state_d = MISS_REQ;
          end
        end
        MISS_REQ: begin
          ifill_req_valid_o = 1'b1;
          if (flush_i) flush_pend_d = 1'b1;
          // Once the fill is accepted its response must still be absorbed, so a kill is deferred.
          if (ifill_req_ready_i) begin
            state_d = MISS_WAIT;
            if (kill_i) kill_pend_d = 1'b1;
          end else if (kill_i) begin
            state_d = IDLE;
          end
        end
        MISS_WAIT: begin
          if (kill_i)  kill_pend_d  = 1'b1;
          if (flush_i) flush_pend_d = 1'b1;
          if (ifill_resp_valid_i) begin
            fill_we     = 1'b1;
            wr_en_o     = victim;
            kill_pend_d = 1'b0;
            if (flush_pend_q || flush_i)     state_d = FLUSH;
            else if (kill_pend_q || kill_i)  state_d = IDLE;
            else                             state_d = REPLAY;
          end
        end
        REPLAY: begin
          if (flush_i) flush_pend_d = 1'b1;
          if (kill_i) begin
            state_d = IDLE;
          end else begin
            rd_en_o  = 1'b1;
            rd_idx_o = idx_q;
            state_d  = COMPARE;
          end
        end
        FLUSH: begin
          flush_pend_d = 1'b0;
          state_d      = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      rr_q         <= '0;
      kill_pend_q  <= 1'b0;
      flush_pend_q <= 1'b0;
      for (int s = 0; s < N_SETS; s++) valid_q[s] <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      kill_pend_q  <= kill_pend_d;
      flush_pend_q <= flush_pend_d;
      if (state_q == FLUSH) begin
        for (int s = 0; s < N_SETS; s++) valid_q[s] <= '0;
      end else if (fill_we) begin
        valid_q[idx_q] <= set_valid | victim;
      end
      if (fill_we) rr_q <= rr_q + PTR_W'(1);
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else begin
      if (resp_valid_o && (hit_cnt_o != '1)) hit_cnt_o <= hit_cnt_o + 1'b1;
      if ((state_q == COMPARE) && (state_d == MISS_REQ) && (miss_cnt_o != '1))
        miss_cnt_o <= miss_cnt_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sargantana_icache_ctrl.sv
// Self-checking bench for sargantana_icache_ctrl: table-driven lookups plus hand-written
// kill/flush/reset sequences, with a scoreboard for responses and fill writes.
module tb_sargantana_icache_ctrl;

  localparam int NW = 4;
  localparam int IW = 6;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          req_valid_i;
  logic          req_ready_o;
  logic [IW-1:0] req_idx_i;
  logic          tag_valid_i;
  logic          kill_i;
  logic          flush_i;
  logic [NW-1:0] cline_hit_i;
  logic          rd_en_o;
  logic [IW-1:0] rd_idx_o;
  logic          cmp_enable_q_o;
  logic [NW-1:0] way_valid_bits_o;
  logic          resp_valid_o;
  logic          ifill_req_valid_o;
  logic          ifill_req_ready_i;
  logic          ifill_resp_valid_i;
  logic [NW-1:0] wr_en_o;
  logic [IW-1:0] wr_idx_o;

  always #5 clk = ~clk;

  sargantana_icache_ctrl #(
    .ICACHE_N_WAY     (NW),
    .ICACHE_IDX_WIDTH (IW)
  ) dut (
    .clk_i              (clk),
    .rst_i              (rst_i),
    .req_valid_i        (req_valid_i),
    .req_ready_o        (req_ready_o),
    .req_idx_i          (req_idx_i),
    .tag_valid_i        (tag_valid_i),
    .kill_i             (kill_i),
    .flush_i            (flush_i),
    .cline_hit_i        (cline_hit_i),
    .rd_en_o            (rd_en_o),
    .rd_idx_o           (rd_idx_o),
    .cmp_enable_q_o     (cmp_enable_q_o),
    .way_valid_bits_o   (way_valid_bits_o),
    .resp_valid_o       (resp_valid_o),
    .ifill_req_valid_o  (ifill_req_valid_o),
    .ifill_req_ready_i  (ifill_req_ready_i),
    .ifill_resp_valid_i (ifill_resp_valid_i),
    .wr_en_o            (wr_en_o),
    .wr_idx_o           (wr_idx_o)
  );

  // exp_victim == 0 means the first compare is a hit; otherwise it is the expected fill way.
  typedef struct {
    logic [IW-1:0] idx;
    logic [NW-1:0] hit;
    logic [NW-1:0] exp_victim;
    logic [NW-1:0] exp_wvb;
    int            tv_delay;
    int            rdy_delay;
    int            resp_delay;
  } vec_t;

  typedef struct {
    bit            is_fill;
    logic [NW-1:0] wr_en;
    logic [IW-1:0] wr_idx;
  } sb_t;

  sb_t  sb[$];
  sb_t  mon_e;
  vec_t vecs[9];
  int   total = 0;
  int   bad   = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h want=%0h", name, actual, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rv, input logic [IW-1:0] idx, input logic tv, input logic [NW-1:0] hit);
    req_valid_i = rv;
    req_idx_i   = idx;
    tag_valid_i = tv;
    cline_hit_i = hit;
  endtask

  // Every response or fill write the DUT produces must match the oldest expected event.
  always @(negedge clk) begin
    if (!rst_i && (resp_valid_o || (wr_en_o != '0))) begin
      if (sb.size() == 0) begin
        checkOutput("sb_unexpected", {27'd0, resp_valid_o, wr_en_o}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.is_fill) begin
          checkOutput("sb_fill_wr_en", wr_en_o, mon_e.wr_en);
          checkOutput("sb_fill_wr_idx", wr_idx_o, mon_e.wr_idx);
          checkOutput("sb_fill_no_resp", resp_valid_o, 0);
        end else begin
          checkOutput("sb_resp_valid", resp_valid_o, 1);
          checkOutput("sb_resp_no_wr", wr_en_o, 0);
        end
      end
    end
  end

  task automatic pushResp();
    sb.push_back('{is_fill: 1'b0, wr_en: '0, wr_idx: '0});
  endtask

  task automatic pushFill(input logic [NW-1:0] way, input logic [IW-1:0] idx);
    sb.push_back('{is_fill: 1'b1, wr_en: way, wr_idx: idx});
  endtask

  task automatic runLookup(input vec_t v);
    applyStimulus(1'b1, v.idx, 1'b0, '0);
    @(negedge clk);
    checkOutput("accept_ready", req_ready_o, 1);
    checkOutput("accept_rd_en", rd_en_o, 1);
    checkOutput("accept_rd_idx", rd_idx_o, v.idx);
    stepCycle();
    applyStimulus(1'b0, '0, 1'b0, '0);
    for (int c = 0; c < v.tv_delay; c++) begin
      @(negedge clk);
      checkOutput("tagwait_cmp", cmp_enable_q_o, 1);
      checkOutput("tagwait_rd_en", rd_en_o, 1);
      checkOutput("tagwait_rd_idx", rd_idx_o, v.idx);
      stepCycle();
    end
    applyStimulus(1'b0, '0, 1'b1, v.hit);
    if (v.exp_victim == '0) pushResp();
    @(negedge clk);
    checkOutput("cmp_enable", cmp_enable_q_o, 1);
    checkOutput("way_valid_bits", way_valid_bits_o, v.exp_wvb);
    checkOutput("cmp_no_fill_req", ifill_req_valid_o, 0);
    stepCycle();
    applyStimulus(1'b0, '0, 1'b0, '0);
    if (v.exp_victim != '0) begin
      for (int c = 0; c < v.rdy_delay; c++) begin
        @(negedge clk);
        checkOutput("fill_req_held", ifill_req_valid_o, 1);
        stepCycle();
      end
      ifill_req_ready_i = 1'b1;
      @(negedge clk);
      checkOutput("fill_req_valid", ifill_req_valid_o, 1);
      stepCycle();
      ifill_req_ready_i = 1'b0;
      for (int c = 0; c < v.resp_delay; c++) begin
        @(negedge clk);
        checkOutput("fill_wait_no_req", ifill_req_valid_o, 0);
        stepCycle();
      end
      ifill_resp_valid_i = 1'b1;
      pushFill(v.exp_victim, v.idx);
      @(negedge clk);
      stepCycle();
      ifill_resp_valid_i = 1'b0;
      @(negedge clk);
      checkOutput("replay_rd_en", rd_en_o, 1);
      checkOutput("replay_rd_idx", rd_idx_o, v.idx);
      stepCycle();
      applyStimulus(1'b0, '0, 1'b1, v.exp_victim);
      pushResp();
      @(negedge clk);
      stepCycle();
      applyStimulus(1'b0, '0, 1'b0, '0);
    end
    @(negedge clk);
    checkOutput("back_idle_ready", req_ready_o, 1);
    stepCycle();
  endtask

  // Drives a cold miss on idx up to the cycle the fill request has been accepted (now in MISS_WAIT).
  task automatic missToWait(input logic [IW-1:0] idx);
    applyStimulus(1'b1, idx, 1'b0, '0);
    stepCycle();
    applyStimulus(1'b0, '0, 1'b1, '0);
    stepCycle();
    applyStimulus(1'b0, '0, 1'b0, '0);
    ifill_req_ready_i = 1'b1;
    stepCycle();
    ifill_req_ready_i = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_req_ready"}, req_ready_o, 0);
    checkOutput({tag, "_rd_en"}, rd_en_o, 0);
    checkOutput({tag, "_rd_idx"}, rd_idx_o, 0);
    checkOutput({tag, "_cmp"}, cmp_enable_q_o, 0);
    checkOutput({tag, "_wvb"}, way_valid_bits_o, 0);
    checkOutput({tag, "_resp"}, resp_valid_o, 0);
    checkOutput({tag, "_fill_req"}, ifill_req_valid_o, 0);
    checkOutput({tag, "_wr_en"}, wr_en_o, 0);
    checkOutput({tag, "_wr_idx"}, wr_idx_o, 0);
  endtask

  initial begin
    // Pointer starts at 0; four fills of set 7 walk it round once, so the fifth fill wraps to way 0.
    vecs[0] = '{idx: 6'd5,  hit: 4'b0010, exp_victim: 4'b0000, exp_wvb: 4'b0000, tv_delay: 0, rdy_delay: 0, resp_delay: 0};
    vecs[1] = '{idx: 6'd7,  hit: 4'b0000, exp_victim: 4'b0001, exp_wvb: 4'b0000, tv_delay: 0, rdy_delay: 0, resp_delay: 0};
    vecs[2] = '{idx: 6'd7,  hit: 4'b0000, exp_victim: 4'b0010, exp_wvb: 4'b0001, tv_delay: 0, rdy_delay: 1, resp_delay: 0};
    vecs[3] = '{idx: 6'd7,  hit: 4'b0000, exp_victim: 4'b0100, exp_wvb: 4'b0011, tv_delay: 1, rdy_delay: 0, resp_delay: 2};
    vecs[4] = '{idx: 6'd7,  hit: 4'b0000, exp_victim: 4'b1000, exp_wvb: 4'b0111, tv_delay: 0, rdy_delay: 0, resp_delay: 1};
    vecs[5] = '{idx: 6'd7,  hit: 4'b0000, exp_victim: 4'b0001, exp_wvb: 4'b1111, tv_delay: 0, rdy_delay: 0, resp_delay: 0};
    vecs[6] = '{idx: 6'd3,  hit: 4'b0000, exp_victim: 4'b0001, exp_wvb: 4'b0000, tv_delay: 2, rdy_delay: 2, resp_delay: 3};
    vecs[7] = '{idx: 6'd7,  hit: 4'b1000, exp_victim: 4'b0000, exp_wvb: 4'b1111, tv_delay: 0, rdy_delay: 0, resp_delay: 0};
    vecs[8] = '{idx: 6'd3,  hit: 4'b0011, exp_victim: 4'b0000, exp_wvb: 4'b0001, tv_delay: 0, rdy_delay: 0, resp_delay: 0};

    rst_i = 1'b1;
    kill_i = 1'b0;
    flush_i = 1'b0;
    ifill_req_ready_i = 1'b0;
    ifill_resp_valid_i = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, '0);
    stepCycle();
    @(negedge clk);
    checkAllZero("reset");
    stepCycle();
    rst_i = 1'b0;
    @(negedge clk);
    checkOutput("post_reset_ready", req_ready_o, 1);
    stepCycle();

    for (int i = 0; i < 9; i++) runLookup(vecs[i]);

    $display("[TB] kill in COMPARE");
    applyStimulus(1'b1, 6'd20, 1'b0, '0);
    stepCycle();
    applyStimulus(1'b0, '0, 1'b1, '0);
    kill_i = 1'b1;
    @(negedge clk);
    checkOutput("kill_cmp_no_resp", resp_valid_o, 0);
    stepCycle();
    kill_i = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, '0);
    @(negedge clk);
    checkOutput("kill_cmp_idle", req_ready_o, 1);
    checkOutput("kill_cmp_no_fill", ifill_req_valid_o, 0);
    stepCycle();

    $display("[TB] kill in MISS_WAIT");
    missToWait(6'd9);
    kill_i = 1'b1;
    @(negedge clk);
    checkOutput("kill_wait_no_wr", wr_en_o, 0);
    stepCycle();
    kill_i = 1'b0;
    ifill_resp_valid_i = 1'b1;
    pushFill(4'b0001, 6'd9);
    @(negedge clk);
    stepCycle();
    ifill_resp_valid_i = 1'b0;
    @(negedge clk);
    checkOutput("kill_wait_idle", req_ready_o, 1);
    checkOutput("kill_wait_no_replay", rd_en_o, 0);
    stepCycle();
    runLookup('{idx: 6'd9, hit: 4'b0001, exp_victim: 4'b0000, exp_wvb: 4'b0001, tv_delay: 0, rdy_delay: 0, resp_delay: 0});

    $display("[TB] flush in MISS_WAIT");
    missToWait(6'd11);
    flush_i = 1'b1;
    stepCycle();
    flush_i = 1'b0;
    ifill_resp_valid_i = 1'b1;
    pushFill(4'b0001, 6'd11);
    @(negedge clk);
    stepCycle();
    ifill_resp_valid_i = 1'b0;
    @(negedge clk);
    checkOutput("flush_state_ready", req_ready_o, 0);
    stepCycle();
    @(negedge clk);
    checkOutput("flush_done_ready", req_ready_o, 1);
    stepCycle();
    runLookup('{idx: 6'd11, hit: 4'b0000, exp_victim: 4'b0001, exp_wvb: 4'b0000, tv_delay: 0, rdy_delay: 0, resp_delay: 0});
    runLookup('{idx: 6'd7,  hit: 4'b0100, exp_victim: 4'b0000, exp_wvb: 4'b0000, tv_delay: 0, rdy_delay: 0, resp_delay: 0});

    $display("[TB] reset in MISS_WAIT");
    missToWait(6'd30);
    rst_i = 1'b1;
    @(negedge clk);
    checkAllZero("midreset");
    stepCycle();
    rst_i = 1'b0;
    ifill_resp_valid_i = 1'b1;
    @(negedge clk);
    checkOutput("late_resp_no_wr", wr_en_o, 0);
    checkOutput("late_resp_idle", req_ready_o, 1);
    stepCycle();
    ifill_resp_valid_i = 1'b0;
    runLookup('{idx: 6'd11, hit: 4'b0001, exp_victim: 4'b0000, exp_wvb: 4'b0000, tv_delay: 0, rdy_delay: 0, resp_delay: 0});

    stepCycle();
    checkOutput("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
